// File: rtl/rs_queue_if.sv
// Dispatch-to-reservation-station bus: insert lanes, wakeup broadcasts,
// per-unit issue handshake, flush and occupancy.
interface rs_queue_if #(
  parameter int unsigned BWIDTH = 57,
  parameter int unsigned UNITS  = 5,
  parameter int unsigned UBITS  = 3,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned INSERT = 4,
  parameter int unsigned WAKE   = 5,
  parameter int unsigned RBITS  = 5
);
  localparam int unsigned CBITS = $clog2(DEPTH + 1);

  logic                      i_flush;
  logic [INSERT-1:0]         i_ins_valid;
  logic [INSERT*BWIDTH-1:0]  i_ins_bundle;
  logic [INSERT*UBITS-1:0]   i_ins_unit;
  logic [INSERT*RBITS-1:0]   i_ins_rs1;
  logic [INSERT*RBITS-1:0]   i_ins_rs2;
  logic [INSERT-1:0]         i_ins_rdy1;
  logic [INSERT-1:0]         i_ins_rdy2;
  logic [INSERT-1:0]         o_ins_accept;
  logic [WAKE-1:0]           i_wake_valid;
  logic [WAKE*RBITS-1:0]     i_wake_reg;
  logic [UNITS-1:0]          o_issue_valid;
  logic [UNITS*BWIDTH-1:0]   o_issue_bundle;
  logic [UNITS-1:0]          i_issue_ready;
  logic [UNITS*CBITS-1:0]    o_count;

  modport master (
    output i_flush, i_ins_valid, i_ins_bundle, i_ins_unit, i_ins_rs1, i_ins_rs2,
           i_ins_rdy1, i_ins_rdy2, i_wake_valid, i_wake_reg, i_issue_ready,
    input  o_ins_accept, o_issue_valid, o_issue_bundle, o_count
  );

  modport slave (
    input  i_flush, i_ins_valid, i_ins_bundle, i_ins_unit, i_ins_rs1, i_ins_rs2,
           i_ins_rdy1, i_ins_rdy2, i_wake_valid, i_wake_reg, i_issue_ready,
    output o_ins_accept, o_issue_valid, o_issue_bundle, o_count
  );
endinterface

// File: rtl/rs_queue.sv
// Per-unit collapsing, age-ordered reservation station with wakeup and oldest-ready issue.
// Define RS_QUEUE_WAKE_BYPASS_EN to let same-cycle wakes count as ready at select.
module rs_queue #(
  parameter int unsigned BWIDTH = 57,
  parameter int unsigned UNITS  = 5,
  parameter int unsigned UBITS  = 3,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned INSERT = 4,
  parameter int unsigned WAKE   = 5,
  parameter int unsigned RBITS  = 5
) (
  input  logic      i_clk,
  input  logic      i_rst,
  rs_queue_if.slave bus
);
  localparam int unsigned CBITS = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [BWIDTH-1:0] bundle;
    logic [RBITS-1:0]  rs1;
    logic [RBITS-1:0]  rs2;
    logic              rdy1;
    logic              rdy2;
  } entry_t;

  entry_t            q_ent      [UNITS][DEPTH];
  entry_t            n_ent      [UNITS][DEPTH];
  logic [CBITS-1:0]  q_cnt      [UNITS];
  logic [CBITS-1:0]  n_cnt      [UNITS];
  logic [CBITS-1:0]  pend       [UNITS];
  logic [DEPTH-1:0]  sel_oh     [UNITS];
  logic [BWIDTH-1:0] sel_bundle [UNITS];
  logic [INSERT-1:0] ins_accept;
  logic [UNITS-1:0]  issue_valid;
  logic [UBITS-1:0]  lane_unit;
  logic              blocked;
  logic              room;
  logic              op1_ok;
  logic              op2_ok;
  logic              gone;
  logic              kill;

  assign kill = i_rst | bus.i_flush;

  function automatic logic wake_hit(input logic [WAKE-1:0]       wv,
                                    input logic [WAKE*RBITS-1:0] wr,
                                    input logic [RBITS-1:0]      r);
    logic hit;
    hit = 1'b0;
    for (int unsigned w = 0; w < WAKE; w++)
      if (wv[w] && wr[w*RBITS +: RBITS] == r) hit = 1'b1;
    return hit;
  endfunction

  // In-order acceptance against pre-issue occupancy; the first rejected lane blocks the rest.
  always_comb begin
    ins_accept = '0;
    blocked    = 1'b0;
    room       = 1'b0;
    lane_unit  = '0;
    for (int unsigned u = 0; u < UNITS; u++) pend[u] = '0;
    for (int unsigned k = 0; k < INSERT; k++) begin
      lane_unit = bus.i_ins_unit[k*UBITS +: UBITS];
      room      = 1'b0;
      for (int unsigned u = 0; u < UNITS; u++)
        if (lane_unit == UBITS'(u) && 32'(q_cnt[u]) + 32'(pend[u]) < DEPTH) room = 1'b1;
      if (bus.i_ins_valid[k] && !blocked) begin
        if (room && !kill) begin
          ins_accept[k] = 1'b1;
          for (int unsigned u = 0; u < UNITS; u++)
            if (lane_unit == UBITS'(u)) pend[u] = pend[u] + CBITS'(1);
        end else begin
          blocked = 1'b1;
        end
      end
    end
  end

  always_comb begin
    issue_valid = '0;
    op1_ok      = 1'b0;
    op2_ok      = 1'b0;
    for (int unsigned u = 0; u < UNITS; u++) begin
      sel_oh[u]     = '0;
      sel_bundle[u] = '0;
      for (int unsigned e = 0; e < DEPTH; e++) begin
        op1_ok = q_ent[u][e].rdy1;
        op2_ok = q_ent[u][e].rdy2;
`ifdef RS_QUEUE_WAKE_BYPASS_EN
        op1_ok = op1_ok | wake_hit(bus.i_wake_valid, bus.i_wake_reg, q_ent[u][e].rs1);
        op2_ok = op2_ok | wake_hit(bus.i_wake_valid, bus.i_wake_reg, q_ent[u][e].rs2);
`endif
        if (!issue_valid[u] && !kill && e < 32'(q_cnt[u]) && op1_ok && op2_ok) begin
          issue_valid[u] = 1'b1;
          sel_oh[u][e]   = 1'b1;
          sel_bundle[u]  = q_ent[u][e].bundle;
        end
      end
    end
  end

  always_comb begin
    bus.o_ins_accept   = ins_accept;
    bus.o_issue_valid  = issue_valid;
    bus.o_issue_bundle = '0;
    bus.o_count        = '0;
    for (int unsigned u = 0; u < UNITS; u++) begin
      bus.o_issue_bundle[u*BWIDTH +: BWIDTH] = sel_bundle[u];
      bus.o_count[u*CBITS +: CBITS]          = q_cnt[u];
    end
  end

  // Next state: collapse over the issued slot, apply wakes, then append accepted lanes.
  always_comb begin
    gone = 1'b0;
    for (int unsigned u = 0; u < UNITS; u++) begin
      n_cnt[u] = q_cnt[u];
      for (int unsigned e = 0; e < DEPTH; e++) n_ent[u][e] = q_ent[u][e];
    end
    for (int unsigned u = 0; u < UNITS; u++) begin
      gone = 1'b0;
      for (int unsigned e = 0; e + 1 < DEPTH; e++) begin
        gone = gone | (sel_oh[u][e] & bus.i_issue_ready[u]);
        if (gone) n_ent[u][e] = q_ent[u][e+1];
      end
      if (issue_valid[u] && bus.i_issue_ready[u]) n_cnt[u] = q_cnt[u] - CBITS'(1);
      for (int unsigned e = 0; e < DEPTH; e++) begin
        n_ent[u][e].rdy1 = n_ent[u][e].rdy1 |
                           wake_hit(bus.i_wake_valid, bus.i_wake_reg, n_ent[u][e].rs1);
        n_ent[u][e].rdy2 = n_ent[u][e].rdy2 |
                           wake_hit(bus.i_wake_valid, bus.i_wake_reg, n_ent[u][e].rs2);
      end
      for (int unsigned k = 0; k < INSERT; k++) begin
        if (ins_accept[k] && bus.i_ins_unit[k*UBITS +: UBITS] == UBITS'(u)) begin
          for (int unsigned e = 0; e < DEPTH; e++) begin
            if (e == 32'(n_cnt[u])) begin
              n_ent[u][e].bundle = bus.i_ins_bundle[k*BWIDTH +: BWIDTH];
              n_ent[u][e].rs1    = bus.i_ins_rs1[k*RBITS +: RBITS];
              n_ent[u][e].rs2    = bus.i_ins_rs2[k*RBITS +: RBITS];
              n_ent[u][e].rdy1   = bus.i_ins_rdy1[k] | (bus.i_ins_rs1[k*RBITS +: RBITS] == '0) |
                                   wake_hit(bus.i_wake_valid, bus.i_wake_reg,
                                            bus.i_ins_rs1[k*RBITS +: RBITS]);
              n_ent[u][e].rdy2   = bus.i_ins_rdy2[k] | (bus.i_ins_rs2[k*RBITS +: RBITS] == '0) |
                                   wake_hit(bus.i_wake_valid, bus.i_wake_reg,
                                            bus.i_ins_rs2[k*RBITS +: RBITS]);
            end
          end
          n_cnt[u] = n_cnt[u] + CBITS'(1);
        end
      end
    end
    if (bus.i_flush)
      for (int unsigned u = 0; u < UNITS; u++) n_cnt[u] = '0;
  end

  // Only the counts need reset: slots at or above the count are never observed.
  always_ff @(posedge i_clk) begin
    for (int unsigned u = 0; u < UNITS; u++) begin
      if (i_rst) q_cnt[u] <= '0;
      else       q_cnt[u] <= n_cnt[u];
      for (int unsigned e = 0; e < DEPTH; e++) q_ent[u][e] <= n_ent[u][e];
    end
  end
endmodule

// File: tb/tb_rs_queue.sv
// Randomised and directed bench for rs_queue against a single age-ordered
// queue model (all units share one list, each entry tagged with its unit).
module tb_rs_queue;
  localparam int unsigned BWIDTH = 57;
  localparam int unsigned UNITS  = 5;
  localparam int unsigned UBITS  = 3;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned INSERT = 4;
  localparam int unsigned WAKE   = 5;
  localparam int unsigned RBITS  = 5;
  localparam int unsigned CBITS  = $clog2(DEPTH + 1);
`ifdef RS_QUEUE_WAKE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rs_queue_if #(.BWIDTH(BWIDTH), .UNITS(UNITS), .UBITS(UBITS), .DEPTH(DEPTH),
                .INSERT(INSERT), .WAKE(WAKE), .RBITS(RBITS)) bus ();

  rs_queue #(.BWIDTH(BWIDTH), .UNITS(UNITS), .UBITS(UBITS), .DEPTH(DEPTH),
             .INSERT(INSERT), .WAKE(WAKE), .RBITS(RBITS)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  typedef struct {
    int                unit;
    logic [BWIDTH-1:0] bundle;
    logic [RBITS-1:0]  rs1;
    logic [RBITS-1:0]  rs2;
    bit                rdy1;
    bit                rdy2;
  } ent_t;

  ent_t              model [$];
  int                total = 0;
  int                bad   = 0;
  logic [INSERT-1:0] obs_acc;
  logic [UNITS-1:0]  obs_iv;
  logic [UNITS*CBITS-1:0] obs_cnt;
  logic [BWIDTH-1:0] obs_b0;
  logic [BWIDTH-1:0] lane_b [INSERT];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic bit whit(input logic [RBITS-1:0] r);
    for (int w = 0; w < WAKE; w++)
      if (bus.i_wake_valid[w] && bus.i_wake_reg[w*RBITS +: RBITS] == r) return 1'b1;
    return 1'b0;
  endfunction

  task automatic idle();
    bus.i_flush       = 1'b0;
    bus.i_ins_valid   = '0;
    bus.i_ins_bundle  = '0;
    bus.i_ins_unit    = '0;
    bus.i_ins_rs1     = '0;
    bus.i_ins_rs2     = '0;
    bus.i_ins_rdy1    = '0;
    bus.i_ins_rdy2    = '0;
    bus.i_wake_valid  = '0;
    bus.i_wake_reg    = '0;
    bus.i_issue_ready = '1;
  endtask

  task automatic lane(input int k, input int unit, input int rs1, input int rs2,
                      input bit r1, input bit r2);
    lane_b[k] = BWIDTH'({$urandom, $urandom});
    bus.i_ins_valid[k]                   = 1'b1;
    bus.i_ins_unit[k*UBITS +: UBITS]     = UBITS'(unit);
    bus.i_ins_rs1[k*RBITS +: RBITS]      = RBITS'(rs1);
    bus.i_ins_rs2[k*RBITS +: RBITS]      = RBITS'(rs2);
    bus.i_ins_rdy1[k]                    = r1;
    bus.i_ins_rdy2[k]                    = r2;
    bus.i_ins_bundle[k*BWIDTH +: BWIDTH] = lane_b[k];
  endtask

  task automatic wake(input int w, input int r);
    bus.i_wake_valid[w]              = 1'b1;
    bus.i_wake_reg[w*RBITS +: RBITS] = RBITS'(r);
  endtask

  // Check all outputs at the falling edge against the model, then advance the model.
  task automatic cycle();
    int                occ  [UNITS];
    int                pend [UNITS];
    int                sel  [UNITS];
    logic [INSERT-1:0] e_acc;
    logic [UNITS-1:0]  e_iv;
    logic [UNITS*CBITS-1:0] e_cnt;
    logic [BWIDTH-1:0] e_b;
    bit                blocked;
    int                u;
    ent_t              keep [$];
    ent_t              n;
    @(negedge clk);
    for (int i = 0; i < UNITS; i++) begin
      occ[i] = 0; pend[i] = 0; sel[i] = -1;
    end
    foreach (model[i]) begin
      u = model[i].unit;
      occ[u]++;
      if (sel[u] < 0 && (model[i].rdy1 || (BYPASS && whit(model[i].rs1)))
                     && (model[i].rdy2 || (BYPASS && whit(model[i].rs2))))
        sel[u] = i;
    end
    e_acc   = '0;
    blocked = 1'b0;
    for (int k = 0; k < INSERT; k++) begin
      if (bus.i_ins_valid[k] && !blocked) begin
        u = int'(bus.i_ins_unit[k*UBITS +: UBITS]);
        if (!rst && !bus.i_flush && u < UNITS && occ[u] + pend[u] < DEPTH) begin
          e_acc[k] = 1'b1;
          pend[u]++;
        end else begin
          blocked = 1'b1;
        end
      end
    end
    obs_acc = bus.o_ins_accept;
    obs_iv  = bus.o_issue_valid;
    obs_cnt = bus.o_count;
    obs_b0  = bus.o_issue_bundle[BWIDTH-1:0];
    check("accept", 64'(obs_acc), 64'(e_acc));
    if (!rst) begin
      e_cnt = '0;
      for (int i = 0; i < UNITS; i++) begin
        e_iv[i] = !bus.i_flush && sel[i] >= 0;
        e_cnt[i*CBITS +: CBITS] = CBITS'(occ[i]);
        e_b = '0;
        if (e_iv[i]) e_b = model[sel[i]].bundle;
        check($sformatf("bundle%0d", i), 64'(bus.o_issue_bundle[i*BWIDTH +: BWIDTH]), 64'(e_b));
      end
      check("issue_valid", 64'(obs_iv), 64'(e_iv));
      check("count", 64'(obs_cnt), 64'(e_cnt));
    end
    if (rst || bus.i_flush) begin
      model.delete();
    end else begin
      foreach (model[i]) begin
        u = model[i].unit;
        if (!(sel[u] == i && bus.i_issue_ready[u])) keep.push_back(model[i]);
      end
      foreach (keep[i]) begin
        keep[i].rdy1 = keep[i].rdy1 || whit(keep[i].rs1);
        keep[i].rdy2 = keep[i].rdy2 || whit(keep[i].rs2);
      end
      for (int k = 0; k < INSERT; k++) begin
        if (e_acc[k]) begin
          n.unit   = int'(bus.i_ins_unit[k*UBITS +: UBITS]);
          n.bundle = bus.i_ins_bundle[k*BWIDTH +: BWIDTH];
          n.rs1    = bus.i_ins_rs1[k*RBITS +: RBITS];
          n.rs2    = bus.i_ins_rs2[k*RBITS +: RBITS];
          n.rdy1   = bus.i_ins_rdy1[k] || n.rs1 == 0 || whit(n.rs1);
          n.rdy2   = bus.i_ins_rdy2[k] || n.rs2 == 0 || whit(n.rs2);
          keep.push_back(n);
        end
      end
      model = keep;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    lane(0, 0, 0, 0, 1'b1, 1'b1);
    cycle();
    check("rst_accept", 64'(obs_acc), 64'd0);
    idle();
    cycle();
    rst = 1'b0;
    cycle();
    check("rst_valid", 64'(obs_iv), 64'd0);
    check("rst_count", 64'(obs_cnt), 64'd0);

    // Four lanes to units {0,0,1,2}, then drain unit 0 in age order.
    lane(0, 0, 1, 2, 1'b1, 1'b1);
    lane(1, 0, 3, 4, 1'b1, 1'b1);
    lane(2, 1, 5, 6, 1'b1, 1'b1);
    lane(3, 2, 7, 8, 1'b1, 1'b1);
    cycle();
    check("t1_accept", 64'(obs_acc), 64'hf);
    bus.i_ins_valid = '0;
    cycle();
    check("t1_valid", 64'(obs_iv), 64'b00111);
    check("t1_lane0", 64'(obs_b0), 64'(lane_b[0]));
    cycle();
    check("t1_lane1", 64'(obs_b0), 64'(lane_b[1]));

    // Fill unit 3 with entries waiting on r3, then try to insert behind it.
    idle();
    bus.i_issue_ready[3] = 1'b0;
    for (int k = 0; k < 4; k++) lane(k, 3, 3, 0, 1'b0, 1'b0);
    cycle();
    idle();
    lane(0, 3, 0, 0, 1'b1, 1'b1);
    lane(1, 0, 0, 0, 1'b1, 1'b1);
    cycle();
    check("t2_full", 64'(obs_acc), 64'd0);
    bus.i_ins_valid = '0;
    bus.i_issue_ready[3] = 1'b0;
    wake(0, 3);
    cycle();
    bus.i_wake_valid = '0;
    bus.i_ins_valid  = 4'b0011;
    bus.i_issue_ready[3] = 1'b1;
    cycle();
    check("t2_fire_full", 64'(obs_acc), 64'd0);
    bus.i_issue_ready[3] = 1'b0;
    cycle();
    check("t2_after", 64'(obs_acc), 64'b0011);

    // Wake-to-issue latency on unit 1.
    idle();
    bus.i_issue_ready[1] = 1'b0;
    lane(0, 1, 7, 0, 1'b0, 1'b0);
    cycle();
    bus.i_ins_valid = '0;
    cycle();
    check("t3_wait", 64'(obs_iv[1]), 64'd0);
    wake(2, 7);
    cycle();
    check("t3_wake", 64'(obs_iv[1]), 64'(BYPASS));
    bus.i_wake_valid = '0;
    cycle();
    check("t3_ready", 64'(obs_iv[1]), 64'd1);

    // Insert capturing a same-cycle wake on rs2.
    idle();
    bus.i_issue_ready = '0;
    lane(0, 4, 0, 9, 1'b1, 1'b0);
    wake(4, 9);
    cycle();
    idle();
    bus.i_issue_ready = '0;
    cycle();
    check("t5_capture", 64'(obs_iv[4]), 64'd1);

    // Flush with concurrent inserts and wakes, then a mid-stream reset.
    for (int i = 0; i < 2; i++) begin
      idle();
      bus.i_issue_ready = '0;
      for (int k = 0; k < 4; k++) lane(k, k, 11, 12, 1'b0, 1'b1);
      cycle();
      for (int k = 0; k < 4; k++) lane(k, k + 1, 0, 0, 1'b1, 1'b1);
      wake(1, 11);
      if (i == 0) bus.i_flush = 1'b1;
      else        rst = 1'b1;
      cycle();
      check("t6_accept", 64'(obs_acc), 64'd0);
      if (i == 0) check("t6_valid", 64'(obs_iv), 64'd0);
      idle();
      rst = 1'b0;
      cycle();
      check("t6_count", 64'(obs_cnt), 64'd0);
      check("t6_empty", 64'(obs_iv), 64'd0);
    end

    // Randomised traffic, including out-of-range units, flushes and resets.
    for (int c = 0; c < 1500; c++) begin
      idle();
      for (int k = 0; k < INSERT; k++)
        if ($urandom_range(0, 2) != 0)
          lane(k, int'($urandom_range(0, 6)), int'($urandom_range(0, 15)),
               int'($urandom_range(0, 15)), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
      for (int w = 0; w < WAKE; w++)
        if ($urandom_range(0, 2) == 0) wake(w, int'($urandom_range(0, 15)));
      bus.i_issue_ready = UNITS'($urandom);
      bus.i_flush = ($urandom_range(0, 39) == 0);
      rst = ($urandom_range(0, 99) == 0);
      cycle();
    end
    rst = 1'b0;
    idle();
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rs_queue.md
Name: rs_queue

Overview:
- Parametrised multi-entry reservation station for the dispatch stage.
- Gives each execution unit a DEPTH-deep age-ordered queue, not a single slot.
- Accepts up to INSERT bundles per cycle in program order and tracks operand readiness through WAKE register-ready broadcasts.
- Per unit, issues the oldest fully-ready entry through a valid/ready handshake.

Parameters:
- BWIDTH, 57, bundle width in bits.
- UNITS, 5, number of execution units (queues).
- UBITS, 3, unit-index width (must satisfy 2**UBITS >= UNITS).
- DEPTH, 4, entries per unit queue (>= 1).
- INSERT, 4, insert lanes per cycle.
- WAKE, 5, wakeup broadcast ports.
- RBITS, 5, architectural/physical register index width.

Ports:
- i_clk  in  1  clock; all state changes on rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_flush  in  1  discard all entries.
- i_ins_valid  in  INSERT  per-lane insert request; lane 0 is oldest.
- i_ins_bundle  in  INSERT*BWIDTH  lane k at [k*BWIDTH +: BWIDTH].
- i_ins_unit  in  INSERT*UBITS  target unit per lane.
- i_ins_rs1, i_ins_rs2  in  INSERT*RBITS  source registers per lane.
- i_ins_rdy1, i_ins_rdy2  in  INSERT  source already ready at dispatch.
- o_ins_accept  out  INSERT  lane accepted this cycle (combinational).
- i_wake_valid  in  WAKE  broadcast valid.
- i_wake_reg  in  WAKE*RBITS  register becoming ready.
- o_issue_valid  out  UNITS  unit u has a ready entry.
- o_issue_bundle  out  UNITS*BWIDTH  oldest ready bundle of unit u.
- i_issue_ready  in  UNITS  unit u consumes o_issue_bundle this cycle.
- o_count  out  UNITS*$clog2(DEPTH+1)  occupancy per unit.

Behaviour:
- Clock and reset: one clock, i_clk. Reset is synchronous and active-high on i_rst.
- Reset: all entries invalid; o_count=0; o_issue_valid=0; o_issue_bundle=0. o_ins_accept=0 while i_rst is high.
- Entry state: valid, bundle, rs1, rs2, rdy1, rdy2.
- Queue order: each unit queue is collapsing; index 0 is the oldest entry.
- Accept rule, in order: lane k is accepted iff all of the following hold:
  - i_ins_valid[k];
  - lanes 0..k-1 are all accepted or not valid, and no lower lane was rejected;
  - unit[k] < UNITS;
  - occupancy(unit) plus the number of lower accepted lanes to the same unit is < DEPTH.
- A rejected lane blocks all higher lanes. Occupancy used is the pre-issue count; a slot freed by a same-cycle issue is usable next cycle.
- Insert write: accepted lanes are appended at the tail in lane order on the next edge, after removal of the issued entry.
- rdy at insert: rdyN = i_ins_rdyN | (rsN==0) | (rsN matches any valid wake this cycle). This is a same-cycle wake capture on insert.
- Wakeup: every valid entry sets rdyN when rsN equals any valid i_wake_reg. rdy bits never clear while the entry lives.
- Select: o_issue_valid[u] = some entry in queue u has rdy1&rdy2. o_issue_bundle[u] = lowest-index such entry, zeroed when not valid. Both are combinational from registered state.
- Issue handshake: fire = o_issue_valid[u] & i_issue_ready[u]. On fire, the selected entry is removed on the edge and higher entries shift down one. At most one issue per unit per cycle.
- Issue latency: a wake at cycle t makes the entry issuable at cycle t+1 (see optional feature).
- Full queue: lanes targeting it are rejected even if the same cycle issues from it.
- Flush: i_flush has priority over insert and issue. All entries are invalidated on the edge, o_ins_accept=0 and o_issue_valid=0 during the flush cycle, and wakes that cycle are dropped.
- Simultaneous wake and issue to the same entry: issue wins; the entry is removed.
- i_rst has priority over i_flush.

Optional Feature:
- Macro: RS_QUEUE_WAKE_BYPASS_EN.
- Defined: the select treats a stored operand as ready if it is stored-ready or matches a valid wake this cycle. A wake at cycle t can therefore issue at cycle t. Only the select timing changes; rdy bits still latch on the edge.
- Undefined: one-cycle wake-to-issue, as described above.

Test Plan:
1. Reset, then insert 4 lanes with units {0,0,1,2}, all rdy → accept=4'b1111; next cycle o_issue_valid=5'b00111 and unit 0 presents the lane-0 bundle. With ready=1, the next cycle unit 0 presents the lane-1 bundle.
2. Fill unit 3 (DEPTH=4), then insert lanes {unit3, unit0} → accept=4'b0000, because lane 1 is blocked behind lane 0. Same stimulus with issue fire on unit 3 → still 0; accepted the following cycle.
3. Insert unit-1 entry with rs1=7 not ready and rs2=0 → issue_valid[1]=0. Wake reg 7 at cycle t → issue_valid[1]=1 at t+1, or at t with RS_QUEUE_WAKE_BYPASS_EN.
4. Unit 2 queue holds [A not ready, B ready] → B issues first. Wake A → A issues next; occupancy goes 2→1→0.
5. Insert lane with rs2=9 while wake reg 9 in the same cycle → entry rdy2=1 and issuable the next cycle.
6. Queues half full, then assert i_flush together with inserts and wakes → accept=0; next cycle all o_count=0 and o_issue_valid=0. Assert i_rst mid-stream → same result.
